draw_engine: RTL and testbench
==============================

Name: draw_engine

Overview:
- Pixel-drawing datapath that answers the race-game control FSM's draw_* requests.
- Accepts one held draw request at a time and walks a rectangular region pixel by pixel.
- Fetches colour from an external sprite/screen ROM with 1-cycle read latency.
- Drives VGA adapter x/y/colour/plot, then returns the matching DoneDraw* flag.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- CAR_W, 8, car sprite width; CAR_H, 8, car sprite height.
- EXPL_W, 16, explosion sprite width; EXPL_H, 16, explosion sprite height.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- draw_background, draw_car, draw_over_car, draw_explosion, draw_start_screen, draw_win_screen  in  1 each  level requests, held by the controller until the matching done is seen
- car_x  in  8  car top-left x; car_y  in  7  car top-left y
- rom_sel  out  3  region select: 0 bg, 1 car, 2 explosion, 3 start, 4 win
- rom_addr  out  15  row-major pixel index within the selected region
- rom_data  in  3  colour returned one clock after rom_addr/rom_sel
- x  out  8; y  out  7; colour  out  3; vga_plot  out  1  VGA adapter pixel write
- DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneDrawExplosion, DoneDrawStartScreen, DoneDrawWinScreen  out  1 each

Behaviour:
- Reset: state IDLE; every output 0, including rom_sel, rom_addr, x, y, colour, vga_plot and all done flags. Applies immediately, including mid-draw; no partial done is produced.
- States:
  - IDLE: select the highest-priority active request and latch job, base_x/base_y, W and H, then go to RUN. Priority order: start_screen > win_screen > background > explosion > over_car > car. Full-screen jobs use base 0,0 and SCREEN_W x SCREEN_H. Car, over_car and explosion use base car_x,car_y. over_car uses rom_sel=0 with rom_addr = screen index of (x,y), which repaints the background under the car.
  - RUN: each clock issue one rom_addr/rom_sel from col/row counters; col wraps at W-1 and increments row. After the address for col=W-1,row=H-1 is issued, go to FLUSH.
  - FLUSH: one clock for the final ROM read, then go to DONE.
  - DONE: hold the job's done flag high while its request stays high. Request low: clear done next clock and return to IDLE.
- Output pipeline: x, y, colour and vga_plot are registered one clock behind the address so they align with rom_data. vga_plot is high exactly once per pixel.
- Latency: if the request is sampled at edge 0, the first address issues after edge 1, pixel k is plotted after edge k+2, and done rises after edge W*H+2.
- Clipping: x=base_x+col and y=base_y+row are computed at 9/8 bits. If x>=SCREEN_W or y>=SCREEN_H, vga_plot=0 for that pixel and the counters still advance, so total timing is unchanged.
- Request dropped during RUN/FLUSH: abort to IDLE next clock, no done, vga_plot=0 from that clock.
- Request switch: a different request arriving while busy is ignored until IDLE.
- Exclusivity: at most one done flag is high at any time.

Optional Feature:
- Macro: DRAW_TRANSPARENCY_EN.
- Defined: for car and explosion jobs, a pixel whose rom_data==3'b000 has vga_plot forced to 0, so the background shows through. Timing is unchanged.
- Undefined: every in-bounds pixel is plotted.

Decomposition:
- Package draw_pkg holds:
  - job encoding and rom_sel constants;
  - state encoding;
  - screen and sprite size defaults;
  - the priority order.
- One sub-module, draw_rect_counter: col/row counter with W/H inputs, start/advance inputs and last/wrap outputs, reused for every job.

Test Plan:
- draw_car held, car_x=20, car_y=30:
  - exactly 64 plots, first at (20,30), last at (27,37);
  - DoneDrawCar rises 66 clocks after the request is sampled;
  - DoneDrawCar clears one clock after the request drops.
- draw_background held: 19200 plots covering (0,0)..(159,119); rom_addr 0..19199 in order; DoneDrawBackground only.
- draw_car with car_x=156, car_y=116: only 16 plots, all in (156..159, 116..119); DoneDrawCar still at clock 66.
- draw_explosion raised, dropped after 10 plots: vga_plot low within 1 clock, no done; a re-request restarts from rom_addr 0.
- draw_start_screen and draw_car raised together:
  - start screen is drawn; car is ignored;
  - Reset pulsed at plot 500 forces all outputs to 0 asynchronously and the next request starts clean.
- DRAW_TRANSPARENCY_EN defined: a car ROM with 10 zero pixels gives 54 plots; undefined, it gives 64.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the draw engine: job and state encodings, ROM region selects,
// default screen/sprite sizes and the request priority order.
package draw_pkg;

  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;
  localparam int unsigned DEF_CAR_W    = 8;
  localparam int unsigned DEF_CAR_H    = 8;
  localparam int unsigned DEF_EXPL_W   = 16;
  localparam int unsigned DEF_EXPL_H   = 16;

  localparam int unsigned NumJobs = 6;

  // Enumerator value doubles as the bit index into request and done vectors.
  typedef enum logic [2:0] {
    JobBackground  = 3'd0,
    JobCar         = 3'd1,
    JobOverCar     = 3'd2,
    JobExplosion   = 3'd3,
    JobStartScreen = 3'd4,
    JobWinScreen   = 3'd5
  } job_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } draw_state_e;

  localparam logic [2:0] RomSelBg    = 3'd0;
  localparam logic [2:0] RomSelCar   = 3'd1;
  localparam logic [2:0] RomSelExpl  = 3'd2;
  localparam logic [2:0] RomSelStart = 3'd3;
  localparam logic [2:0] RomSelWin   = 3'd4;

  // Highest priority first: start > win > background > explosion > over_car > car.
  function automatic job_e pick_job(input logic [NumJobs-1:0] req);
    if (req[JobStartScreen]) return JobStartScreen;
    if (req[JobWinScreen])   return JobWinScreen;
    if (req[JobBackground])  return JobBackground;
    if (req[JobExplosion])   return JobExplosion;
    if (req[JobOverCar])     return JobOverCar;
    return JobCar;
  endfunction

  function automatic logic [2:0] job_rom_sel(input job_e job);
    logic [2:0] sel;
    sel = RomSelBg;
    unique case (job)
      JobCar:         sel = RomSelCar;
      JobExplosion:   sel = RomSelExpl;
      JobStartScreen: sel = RomSelStart;
      JobWinScreen:   sel = RomSelWin;
      default:        sel = RomSelBg;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/draw_if.sv
// Bundle of draw requests, ROM port, VGA adapter port and done flags.
// master: the draw engine; slave: controller / ROM / VGA side.
interface draw_if;

  logic       draw_background;
  logic       draw_car;
  logic       draw_over_car;
  logic       draw_explosion;
  logic       draw_start_screen;
  logic       draw_win_screen;
  logic [7:0] car_x;
  logic [6:0] car_y;

  logic [2:0]  rom_sel;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data;

  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       vga_plot;

  logic DoneDrawBackground;
  logic DoneDrawCar;
  logic DoneDrawOverCar;
  logic DoneDrawExplosion;
  logic DoneDrawStartScreen;
  logic DoneDrawWinScreen;

  modport master (
    input  draw_background, draw_car, draw_over_car, draw_explosion,
           draw_start_screen, draw_win_screen, car_x, car_y, rom_data,
    output rom_sel, rom_addr, x, y, colour, vga_plot,
           DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneDrawExplosion,
           DoneDrawStartScreen, DoneDrawWinScreen
  );

  modport slave (
    output draw_background, draw_car, draw_over_car, draw_explosion,
           draw_start_screen, draw_win_screen, car_x, car_y, rom_data,
    input  rom_sel, rom_addr, x, y, colour, vga_plot,
           DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneDrawExplosion,
           DoneDrawStartScreen, DoneDrawWinScreen
  );

endinterface

// File: rtl/draw_rect_counter.sv
// Column/row walker over a W x H rectangle; wrap_o flags the last column, last_o the last pixel.
module draw_rect_counter #(
  parameter int unsigned ColW = 8,
  parameter int unsigned RowW = 7
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            start_i,
  input  logic            advance_i,
  input  logic [ColW-1:0] w_i,
  input  logic [RowW-1:0] h_i,
  output logic [ColW-1:0] col_o,
  output logic [RowW-1:0] row_o,
  output logic            wrap_o,
  output logic            last_o
);

  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign wrap_o = (col_q == w_i - ColW'(1));
  assign last_o = wrap_o && (row_q == h_i - RowW'(1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (start_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (advance_i) begin
      if (wrap_o) begin
        col_q <= '0;
        row_q <= row_q + RowW'(1);
      end else begin
        col_q <= col_q + ColW'(1);
      end
    end
  end

endmodule

// File: rtl/draw_engine.sv
// Rectangle pixel-drawing datapath: walks a job's region, reads a 1-cycle ROM, plots to VGA.
// Optional macro DRAW_TRANSPARENCY_EN: colour-0 car/explosion pixels are not plotted.
module draw_engine
  import draw_pkg::*;
#(
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned CAR_W    = DEF_CAR_W,
  parameter int unsigned CAR_H    = DEF_CAR_H,
  parameter int unsigned EXPL_W   = DEF_EXPL_W,
  parameter int unsigned EXPL_H   = DEF_EXPL_H
) (
  input logic    Clock,
  input logic    Reset,
  draw_if.master bus
);

  logic [NumJobs-1:0] req;
  assign req = {bus.draw_win_screen, bus.draw_start_screen, bus.draw_explosion,
                bus.draw_over_car, bus.draw_car, bus.draw_background};

  draw_state_e        state_q;
  job_e               job_q;
  logic [7:0]         base_x_q;
  logic [6:0]         base_y_q;
  logic [7:0]         w_q;
  logic [6:0]         h_q;
  logic [14:0]        lin_q;
  logic [14:0]        row_idx_q;
  logic               issue_q;
  logic [8:0]         px_x_q;
  logic [7:0]         px_y_q;
  logic [7:0]         x_q;
  logic [6:0]         y_q;
  logic               plot_q;
  logic [2:0]         rom_sel_q;
  logic [14:0]        rom_addr_q;
  logic [NumJobs-1:0] done_q;

  logic [7:0] col;
  logic [6:0] row;
  logic       cnt_wrap;
  logic       cnt_last;
  logic       job_req;
  logic       advance;

  assign job_req = req[job_q];
  assign advance = (state_q == StRun) && job_req;

  draw_rect_counter #(
    .ColW(8),
    .RowW(7)
  ) u_counter (
    .Clock    (Clock),
    .Reset    (Reset),
    .start_i  (state_q == StIdle),
    .advance_i(advance),
    .w_i      (w_q),
    .h_i      (h_q),
    .col_o    (col),
    .row_o    (row),
    .wrap_o   (cnt_wrap),
    .last_o   (cnt_last)
  );

  // Screen coordinates carry one spare bit so off-screen pixels can be detected.
  logic [8:0]  cur_x;
  logic [7:0]  cur_y;
  logic [14:0] scr_idx;
  logic [14:0] addr_d;
  logic        in_bounds;

  assign cur_x     = {1'b0, base_x_q} + {1'b0, col};
  assign cur_y     = {1'b0, base_y_q} + {1'b0, row};
  assign scr_idx   = row_idx_q + 15'(cur_x);
  assign addr_d    = (job_q == JobOverCar) ? scr_idx : lin_q;
  assign in_bounds = (px_x_q < 9'(SCREEN_W)) && (px_y_q < 8'(SCREEN_H));

  job_e       next_job;
  logic [7:0] next_w;
  logic [6:0] next_h;
  logic [7:0] next_bx;
  logic [6:0] next_by;

  always_comb begin
    next_job = pick_job(req);
    next_w   = 8'(SCREEN_W);
    next_h   = 7'(SCREEN_H);
    next_bx  = '0;
    next_by  = '0;
    unique case (next_job)
      JobCar, JobOverCar: begin
        next_w  = 8'(CAR_W);
        next_h  = 7'(CAR_H);
        next_bx = bus.car_x;
        next_by = bus.car_y;
      end
      JobExplosion: begin
        next_w  = 8'(EXPL_W);
        next_h  = 7'(EXPL_H);
        next_bx = bus.car_x;
        next_by = bus.car_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      job_q      <= JobBackground;
      base_x_q   <= '0;
      base_y_q   <= '0;
      w_q        <= '0;
      h_q        <= '0;
      lin_q      <= '0;
      row_idx_q  <= '0;
      issue_q    <= 1'b0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      plot_q     <= 1'b0;
      rom_sel_q  <= '0;
      rom_addr_q <= '0;
      done_q     <= '0;
    end else begin
      // Second pipeline stage: pixel position lines up with the returning ROM data.
      issue_q <= 1'b0;
      plot_q  <= issue_q && in_bounds;
      x_q     <= px_x_q[7:0];
      y_q     <= px_y_q[6:0];
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            job_q     <= next_job;
            base_x_q  <= next_bx;
            base_y_q  <= next_by;
            w_q       <= next_w;
            h_q       <= next_h;
            lin_q     <= '0;
            row_idx_q <= 15'(next_by) * 15'(SCREEN_W);
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (!job_req) begin
            plot_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            rom_addr_q <= addr_d;
            rom_sel_q  <= job_rom_sel(job_q);
            issue_q    <= 1'b1;
            px_x_q     <= cur_x;
            px_y_q     <= cur_y;
            lin_q      <= lin_q + 15'd1;
            if (cnt_wrap) row_idx_q <= row_idx_q + 15'(SCREEN_W);
            if (cnt_last) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (!job_req) begin
            plot_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (job_req) begin
            done_q[job_q] <= 1'b1;
          end else begin
            done_q  <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic transparent;
`ifdef DRAW_TRANSPARENCY_EN
  assign transparent = ((job_q == JobCar) || (job_q == JobExplosion)) && (bus.rom_data == 3'b000);
`else
  assign transparent = 1'b0;
`endif

  assign bus.rom_sel  = rom_sel_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.vga_plot = plot_q && !transparent;
  assign bus.colour   = plot_q ? bus.rom_data : 3'b000;

  assign bus.DoneDrawBackground  = done_q[JobBackground];
  assign bus.DoneDrawCar         = done_q[JobCar];
  assign bus.DoneDrawOverCar     = done_q[JobOverCar];
  assign bus.DoneDrawExplosion   = done_q[JobExplosion];
  assign bus.DoneDrawStartScreen = done_q[JobStartScreen];
  assign bus.DoneDrawWinScreen   = done_q[JobWinScreen];

endmodule

// File: tb/tb_draw_engine.sv
// Scoreboard bench for draw_engine: stimulus pushes expected plots, a negedge monitor checks them.
module tb_draw_engine;

  localparam int JBG = 0, JCAR = 1, JOVER = 2, JEXPL = 3, JSTART = 4, JWIN = 5;
`ifdef DRAW_TRANSPARENCY_EN
  localparam bit Transp = 1'b1;
`else
  localparam bit Transp = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  draw_if bus();

  draw_engine dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int x;
    int y;
    int colour;
    int addr;
    int sel;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_plots  = 0;

  logic [14:0] prev_addr = '0;
  logic [2:0]  prev_sel  = '0;
  logic [5:0]  done_vec;
  logic [48:0] all_out;

  assign done_vec = {bus.DoneDrawWinScreen, bus.DoneDrawStartScreen, bus.DoneDrawExplosion,
                     bus.DoneDrawOverCar, bus.DoneDrawCar, bus.DoneDrawBackground};
  assign all_out  = {bus.rom_sel, bus.rom_addr, bus.x, bus.y, bus.colour, bus.vga_plot, done_vec};

  // Car ROM starts with ten colour-0 pixels; every other region never returns 0.
  function automatic logic [2:0] rom_fn(input logic [2:0] sel, input logic [14:0] a);
    int v;
    if (sel == 3'd1) begin
      if (a < 15'd10) return 3'd0;
      v = int'(a) % 7 + 1;
    end else begin
      v = ((int'(a) ^ (int'(a) >> 3)) + int'(sel)) % 7 + 1;
    end
    return v[2:0];
  endfunction

  always @(posedge Clock) bus.rom_data <= rom_fn(bus.rom_sel, bus.rom_addr);

  always @(negedge Clock) begin
    pix_t e;
    if (bus.vga_plot === 1'b1) begin
      n_plots++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d) col %0d, required no plot",
                 bus.x, bus.y, bus.colour);
      end else begin
        e = exp_q.pop_front();
        if ({bus.x, bus.y, bus.colour, prev_addr, prev_sel} !==
            {8'(e.x), 7'(e.y), 3'(e.colour), 15'(e.addr), 3'(e.sel)}) begin
          n_fail++;
          $display("FAIL pixel: got (%0d,%0d) col %0d addr %0d sel %0d, required (%0d,%0d) col %0d addr %0d sel %0d",
                   bus.x, bus.y, bus.colour, prev_addr, prev_sel,
                   e.x, e.y, e.colour, e.addr, e.sel);
        end
      end
    end
    prev_addr = bus.rom_addr;
    prev_sel  = bus.rom_sel;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic job_dims(input int job, output int w, output int h, output int sel);
    case (job)
      JCAR:    begin w = 8;   h = 8;   sel = 1; end
      JOVER:   begin w = 8;   h = 8;   sel = 0; end
      JEXPL:   begin w = 16;  h = 16;  sel = 2; end
      JSTART:  begin w = 160; h = 120; sel = 3; end
      JWIN:    begin w = 160; h = 120; sel = 4; end
      default: begin w = 160; h = 120; sel = 0; end
    endcase
  endtask

  task automatic set_req(input int job, input logic v);
    case (job)
      JCAR:    bus.draw_car = v;
      JOVER:   bus.draw_over_car = v;
      JEXPL:   bus.draw_explosion = v;
      JSTART:  bus.draw_start_screen = v;
      JWIN:    bus.draw_win_screen = v;
      default: bus.draw_background = v;
    endcase
  endtask

  task automatic push_job(input int job, input int bx, input int by, input int limit);
    int   w, h, sel, x, y, cnt;
    pix_t p;
    job_dims(job, w, h, sel);
    cnt = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x = bx + c;
        y = by + r;
        if (x < 160 && y < 120 && cnt < limit) begin
          p.x    = x;
          p.y    = y;
          p.sel  = sel;
          p.addr = (job == JOVER) ? y * 160 + x : r * w + c;
          p.colour = int'(rom_fn(3'(sel), 15'(p.addr)));
          if (!(Transp && (job == JCAR || job == JEXPL) && p.colour == 0)) begin
            exp_q.push_back(p);
            cnt++;
          end
        end
      end
    end
  endtask

  task automatic do_job(input string name, input int job, input int bx, input int by,
                        input int exp_plots);
    int w, h, sel, cyc, base;
    job_dims(job, w, h, sel);
    push_job(job, bx, by, 1 << 30);
    base = n_plots;
    @(posedge Clock);
    #1;
    bus.car_x = 8'(bx);
    bus.car_y = 7'(by);
    set_req(job, 1'b1);
    @(posedge Clock);  // request sampled here
    cyc = 0;
    forever begin
      @(negedge Clock);
      if (done_vec != 6'd0 || cyc > w * h + 20) break;
      @(posedge Clock);
      cyc++;
    end
    check({name, "_done_cycle"}, 64'(cyc), 64'(w * h + 2));
    check({name, "_done_flag"}, 64'(done_vec), 64'(1 << job));
    check({name, "_plot_count"}, 64'(n_plots - base), 64'(exp_plots));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    #1 set_req(job, 1'b0);
    @(posedge Clock);
    #1 check({name, "_done_clear"}, 64'(done_vec), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bus.draw_background   = 1'b0;
    bus.draw_car          = 1'b0;
    bus.draw_over_car     = 1'b0;
    bus.draw_explosion    = 1'b0;
    bus.draw_start_screen = 1'b0;
    bus.draw_win_screen   = 1'b0;
    bus.car_x             = '0;
    bus.car_y             = '0;
    #1 Reset = 1'b1;
    #2 check("reset_outputs", 64'(all_out), 64'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock) Reset = 1'b0;
    @(posedge Clock);
    #1 check("post_reset_outputs", 64'(all_out), 64'd0);

    do_job("car", JCAR, 20, 30, Transp ? 54 : 64);
    do_job("background", JBG, 0, 0, 19200);
    do_job("car_clip", JCAR, 156, 116, Transp ? 10 : 16);
    do_job("over_car", JOVER, 10, 5, 64);

    // Explosion dropped after ten plots, then re-requested from scratch.
    push_job(JEXPL, 40, 50, 10);
    base = n_plots;
    @(posedge Clock);
    #1;
    bus.car_x = 8'd40;
    bus.car_y = 7'd50;
    set_req(JEXPL, 1'b1);
    @(posedge Clock);
    repeat (11) @(posedge Clock);
    #1 set_req(JEXPL, 1'b0);
    @(posedge Clock);
    #1 check("expl_abort_plot", 64'(bus.vga_plot), 64'd0);
    repeat (20) @(posedge Clock);
    #1 check("expl_abort_done", 64'(done_vec), 64'd0);
    check("expl_abort_plots", 64'(n_plots - base), 64'd10);
    do_job("explosion", JEXPL, 40, 50, 256);

    // Start screen wins over car; reset lands mid-draw after 500 plots.
    push_job(JSTART, 0, 0, 500);
    base = n_plots;
    @(posedge Clock);
    #1;
    bus.car_x = 8'd20;
    bus.car_y = 7'd30;
    set_req(JSTART, 1'b1);
    set_req(JCAR, 1'b1);
    @(posedge Clock);
    repeat (501) @(posedge Clock);
    @(negedge Clock);
    #1 Reset = 1'b1;
    #1 check("reset_mid_outputs", 64'(all_out), 64'd0);
    check("reset_mid_plots", 64'(n_plots - base), 64'd500);
    @(posedge Clock);
    #1 check("reset_hold_outputs", 64'(all_out), 64'd0);
    set_req(JSTART, 1'b0);
    set_req(JCAR, 1'b0);
    @(negedge Clock) Reset = 1'b0;
    check("reset_queue_empty", 64'(exp_q.size()), 64'd0);

    do_job("car_after_reset", JCAR, 100, 60, Transp ? 54 : 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
